// File: rtl/skew_pkg.sv
// Shared types and the lane-delay helper for the skew/deskew buffer.
package skew_pkg;

  typedef enum logic {
    SKEW   = 1'b0,
    DESKEW = 1'b1
  } skew_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } skew_state_e;

  // Delay in enabled cycles for lane i; skew grows with i, deskew shrinks with i.
  function automatic int unsigned lane_delay(input skew_mode_e mode, input int unsigned i,
                                             input int unsigned base, input int unsigned lanes);
    return (mode == SKEW) ? (base + i) : (base + (lanes - 1 - i));
  endfunction

endpackage

// File: rtl/skew_lane.sv
// One lane: data+valid shift register with a mode-selected tap.
// SKEWBUF_ZERO_FILL_EN forces the data output to zero while the tap is invalid.
module skew_lane
  import skew_pkg::*;
#(
  parameter int unsigned BITS  = 8,
  parameter int unsigned LANES = 8,
  parameter int unsigned BASE  = 8,
  parameter int unsigned IDX   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_en,
  input  logic                   i_flush,
  input  logic                   i_valid,
  input  logic                   i_mode,
  input  logic signed [BITS-1:0] i_data,
  output logic signed [BITS-1:0] o_data,
  output logic                   o_valid
);

  localparam int unsigned D_SKEW   = lane_delay(SKEW, IDX, BASE, LANES);
  localparam int unsigned D_DESKEW = lane_delay(DESKEW, IDX, BASE, LANES);
  // Stages past the deeper of the two taps could never be observed.
  localparam int unsigned DEPTH    = (D_SKEW > D_DESKEW) ? D_SKEW : D_DESKEW;

  logic signed [BITS-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]       r_vld;
  logic signed [BITS-1:0] w_tap_data;
  logic                   w_tap_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++) r_data[k] <= '0;
      r_vld <= '0;
    end else begin
      if (i_en) begin
        r_data[0] <= i_data;
        for (int k = 1; k < int'(DEPTH); k++) r_data[k] <= r_data[k-1];
      end
      // Flush only needs to kill the valid bits; stale data is harmless.
      if (i_flush) begin
        r_vld <= '0;
      end else if (i_en) begin
        r_vld[0] <= i_valid;
        for (int k = 1; k < int'(DEPTH); k++) r_vld[k] <= r_vld[k-1];
      end
    end
  end

  assign w_tap_data = (i_mode == DESKEW) ? r_data[D_DESKEW-1] : r_data[D_SKEW-1];
  assign w_tap_vld  = (i_mode == DESKEW) ? r_vld[D_DESKEW-1]  : r_vld[D_SKEW-1];

`ifdef SKEWBUF_ZERO_FILL_EN
  assign o_data  = w_tap_vld ? w_tap_data : '0;
`else
  assign o_data  = w_tap_data;
`endif
  assign o_valid = w_tap_vld;

endmodule

// File: rtl/skew_buf.sv
// Skew/deskew buffer top: burst FSM, drain counter, mode latch and LANES lanes.
// Optional macro SKEWBUF_ZERO_FILL_EN zero-fills dout on invalid lanes.
module skew_buf
  import skew_pkg::*;
#(
  parameter int unsigned BITS  = 8,
  parameter int unsigned LANES = 8,
  parameter int unsigned BASE  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   mode,
  input  logic                   in_valid,
  input  logic signed [BITS-1:0] din [LANES-1:0],
  output logic signed [BITS-1:0] dout [LANES-1:0],
  output logic [LANES-1:0]       out_valid,
  output logic                   busy,
  output logic                   cur_mode
);

  localparam int unsigned MAXD = BASE + LANES - 1;
  localparam int unsigned CW   = $clog2(MAXD + 1);

  skew_state_e r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic          r_cur_mode, w_mode_nxt;

  assign w_cnt_inc = CW'(r_cnt + CW'(1));

  // Next-state: mode is latched only on the word that opens a burst.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_cur_mode;
    if (flush) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (en) begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
            w_mode_nxt  = mode;
          end
        end
        RUN: begin
          if (in_valid) begin
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == CW'(MAXD)) w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_cur_mode <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cur_mode <= w_mode_nxt;
    end
  end

  assign busy     = (r_state == RUN);
  assign cur_mode = r_cur_mode;

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    skew_lane #(
      .BITS  (BITS),
      .LANES (LANES),
      .BASE  (BASE),
      .IDX   (g)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_en    (en),
      .i_flush (flush),
      .i_valid (in_valid),
      .i_mode  (r_cur_mode),
      .i_data  (din[g]),
      .o_data  (dout[g]),
      .o_valid (out_valid[g])
    );
  end

endmodule

// File: tb/tb_skew_buf.sv
// Scoreboard bench for skew_buf with LANES=4, BITS=8, BASE=2.
module tb_skew_buf;

  localparam int BITS  = 8;
  localparam int LANES = 4;
  localparam int BASE  = 2;
  localparam int MAXD  = BASE + LANES - 1;

  logic                   clk = 1'b0;
  logic                   rst, en, flush, mode, in_valid;
  logic signed [BITS-1:0] din  [LANES-1:0];
  logic signed [BITS-1:0] dout [LANES-1:0];
  logic [LANES-1:0]       out_valid;
  logic                   busy, cur_mode;

  skew_buf #(.BITS(BITS), .LANES(LANES), .BASE(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .mode      (mode),
    .in_valid  (in_valid),
    .din       (din),
    .dout      (dout),
    .out_valid (out_valid),
    .busy      (busy),
    .cur_mode  (cur_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                     lane;
    logic signed [BITS-1:0] d;
    int                     due;
  } exp_t;

  exp_t sb[$];
  int   en_edges  = 0;
  int   last_edge = 0;
  bit   active    = 1'b0;
  logic mode_m    = 1'b0;
  int   n_err     = 0;
  int   n_chk     = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int dly(input logic m, input int i);
    return m ? (BASE + LANES - 1 - i) : (BASE + i);
  endfunction

  // Reference behaviour of one rising edge, using the inputs driven for it.
  task automatic model_edge();
    if (rst) begin
      sb.delete();
      active = 1'b0;
      mode_m = 1'b0;
    end else if (flush) begin
      sb.delete();
      active = 1'b0;
      if (en) en_edges++;
    end else if (en) begin
      en_edges++;
      if (in_valid) begin
        if (!active) mode_m = mode;
        active    = 1'b1;
        last_edge = en_edges;
        for (int i = 0; i < LANES; i++) begin
          exp_t e;
          e.lane = i;
          e.d    = din[i];
          e.due  = en_edges + dly(mode_m, i) - 1;
          sb.push_back(e);
        end
      end
      if (active && (en_edges - last_edge) >= MAXD) active = 1'b0;
    end
  endtask

  task automatic check_outputs();
    for (int k = sb.size() - 1; k >= 0; k--)
      if (sb[k].due < en_edges) sb.delete(k);
    for (int i = 0; i < LANES; i++) begin
      logic                   exp_v;
      logic signed [BITS-1:0] exp_d;
      exp_v = 1'b0;
      exp_d = '0;
      for (int k = 0; k < sb.size(); k++)
        if (sb[k].lane == i && sb[k].due == en_edges) begin
          exp_v = 1'b1;
          exp_d = sb[k].d;
        end
      check_val($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(exp_v));
      if (exp_v) check_val($sformatf("dout[%0d]", i), 32'(dout[i]), 32'(exp_d));
`ifdef SKEWBUF_ZERO_FILL_EN
      else check_val($sformatf("zfill[%0d]", i), 32'(dout[i]), 32'd0);
`endif
      if (rst) check_val($sformatf("rst_dout[%0d]", i), 32'(dout[i]), 32'd0);
    end
    check_val("busy", 32'(busy), 32'(active));
    check_val("cur_mode", 32'(cur_mode), 32'(mode_m));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int c = 0; c < n; c++) tick();
  endtask

  task automatic send(input logic signed [BITS-1:0] a0, input logic signed [BITS-1:0] a1,
                      input logic signed [BITS-1:0] a2, input logic signed [BITS-1:0] a3);
    in_valid = 1'b1;
    din[0] = a0; din[1] = a1; din[2] = a2; din[3] = a3;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset with random inputs.
    rst = 1'b1; en = 1'($urandom); flush = 1'($urandom); mode = 1'($urandom);
    in_valid = 1'($urandom);
    for (int i = 0; i < LANES; i++) din[i] = BITS'($urandom);
    tick();
    in_valid = 1'($urandom); mode = 1'($urandom);
    tick();
    rst = 1'b0; en = 1'b1; flush = 1'b0; mode = 1'b0; in_valid = 1'b0;

    // Skew single word.
    send(8'sd1, -8'sd2, 8'sd3, -8'sd4);
    idle(7);

    // Deskew single word.
    mode = 1'b1;
    send(8'sd1, -8'sd2, 8'sd3, -8'sd4);
    mode = 1'b0;
    idle(7);

    // Skew burst with a 3-cycle stall mid-flight.
    send(8'sd1, 8'sd1, 8'sd1, 8'sd1);
    send(8'sd2, 8'sd2, 8'sd2, 8'sd2);
    send(8'sd3, 8'sd3, 8'sd3, 8'sd3);
    idle(1);
    en = 1'b0;
    idle(3);
    en = 1'b1;
    idle(8);

    // Mode toggled while busy is ignored.
    send(8'sd10, 8'sd11, 8'sd12, 8'sd13);
    mode = 1'b1;
    send(8'sd20, 8'sd21, 8'sd22, 8'sd23);
    idle(2);
    mode = 1'b0;

    // Flush together with a new word.
    flush = 1'b1;
    send(8'sd99, 8'sd98, 8'sd97, 8'sd96);
    flush = 1'b0;
    idle(8);

    // Flush while stalled.
    send(8'sd5, 8'sd6, 8'sd7, 8'sd8);
    en = 1'b0; flush = 1'b1;
    idle(1);
    en = 1'b1; flush = 1'b0;
    idle(7);

    // Random traffic with stalls, mode changes and occasional flush.
    for (int c = 0; c < 120; c++) begin
      en       = ($urandom_range(0, 3) != 0);
      in_valid = ($urandom_range(0, 2) == 0);
      flush    = ($urandom_range(0, 40) == 0);
      mode     = 1'($urandom);
      for (int i = 0; i < LANES; i++) din[i] = BITS'($urandom);
      tick();
    end
    en = 1'b1; flush = 1'b0;
    idle(8);

    // Reset mid-burst discards everything.
    mode = 1'b1;
    send(8'sd40, 8'sd41, 8'sd42, 8'sd43);
    send(8'sd50, 8'sd51, 8'sd52, 8'sd53);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    mode = 1'b0;
    idle(7);

    // Burst restarting right as the previous one drains.
    send(-8'sd128, 8'sd127, -8'sd1, 8'sd0);
    idle(MAXD);
    mode = 1'b1;
    send(8'sd60, 8'sd61, 8'sd62, 8'sd63);
    idle(7);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/skew_buf.md
# skew_buf

Parametrised input-skew / output-deskew buffer for the systolic-array datapath. Each of LANES channels delays its operand by a lane-dependent number of enabled cycles: lane i delay grows with i in skew mode and shrinks with i in deskew mode. Per-lane valid bits travel with the data, and an FSM tracks in-flight traffic. The block sits between the operand memories and the array edge, or between the array result edge and writeback, with the mode latched per burst.

## Interface
- BITS, default 8: operand width, signed.
- LANES, default 8: channel count, ≥1.
- BASE, default 8: minimum lane delay in enabled cycles, ≥1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset; overrides every other input.
- en  in  1  advance; when low, all state holds.
- flush  in  1  discard all in-flight data; synchronous.
- mode  in  1  0 = skew, 1 = deskew; sampled only at burst start.
- in_valid  in  1  din carries a valid vector.
- din  in  LANES×BITS  signed input vector, unpacked [LANES-1:0].
- dout  out  LANES×BITS  signed output vector.
- out_valid  out  LANES  per-lane output valid.
- busy  out  1  high while any valid word is in flight.
- cur_mode  out  1  latched mode.

## Operation
- MAXD = BASE+LANES-1.
- Lane delay D_i:
  - skew: BASE+i.
  - deskew: BASE+(LANES-1-i).
- Each lane is a MAXD-stage data+valid shift register, tapped at stage D_i of the latched mode. All lanes shift together on an enabled edge.
- A word captured on an enabled edge appears on dout[i]/out_valid[i] after the D_i-th enabled edge, counting the capturing edge as the first. For D_i=1 the lane is a plain register.
- FSM states:
  - IDLE → RUN on an enabled edge with in_valid=1. On that edge the mode input is latched into cur_mode, and the captured word uses the new mode.
  - RUN: mode input ignored. Drain counter (width clog2(MAXD+1)) clears on every enabled edge with in_valid=1 and increments on enabled edges with in_valid=0.
  - RUN → IDLE on the edge the counter reaches MAXD. At that point every valid bit has left the lanes.
- busy = (state == RUN).
- flush=1 (with or without en):
  - clears all valid bits and the drain counter.
  - returns the FSM to IDLE.
  - discards the concurrent in_valid word.
  - data stages need not clear.
  - cur_mode holds.
- Reset values: dout = 0, out_valid = 0, busy = 0, cur_mode = 0, all stages and the counter = 0, FSM = IDLE.
- Reset asserted mid-burst discards everything on that edge.
- Arithmetic: none. Data passes bit-exact, with no sign extension or width change.

## Timing
- All outputs are registered; there is no combinational input→output path.
- en low freezes the lanes, the counter and the FSM. Outputs hold their values and arrival slips by the number of stalled cycles.
- Back-to-back in_valid at full rate is supported with no bubbles. A new burst may start on the same edge the FSM returns to IDLE.
- Priority: rst > flush > en.

## Configuration
- SKEWBUF_ZERO_FILL_EN defined: dout[i] is forced to 0 whenever out_valid[i]=0. This supplies the zero padding the array edge needs.
- Not defined: dout[i] shows the raw tap register regardless of valid. This saves the output mux.

## Structure
- Package skew_pkg:
  - typedef enum skew_mode_e {SKEW=0, DESKEW=1}.
  - typedef enum skew_state_e {IDLE, RUN}.
  - function lane_delay(mode, i, BASE, LANES).
- Sub-module skew_lane: one lane with its data+valid shift register, runtime tap select and optional zero-fill. It is instantiated LANES times in a generate loop.
- The top level holds the FSM, the drain counter and the mode latch.

## Test plan
All scenarios use LANES=4, BITS=8, BASE=2, MAXD=5.
- Reset: assert rst 2 cycles with random inputs → dout all 0, out_valid 0000, busy 0, cur_mode 0.
- Skew single word: mode=0, en=1, one cycle in_valid with din={lane0..3}={1,-2,3,-4} → out_valid[0] after 2 edges, [1] after 3, [2] after 4, [3] after 5; values exact; busy falls 5 edges after capture.
- Deskew: mode=1, same stimulus → lane3 appears after 2 edges and lane0 after 5; cur_mode=1.
- Stall: skew burst of 3 words {1..3} on every lane, en held low 3 cycles mid-flight → outputs hold during the stall and every arrival slips by exactly 3 cycles.
- Mode/flush: toggle mode while busy → cur_mode unchanged. Assert flush together with in_valid → next cycle out_valid 0000, busy 0, and the flushed word never appears.
- Zero fill: rerun the skew scenario with SKEWBUF_ZERO_FILL_EN → dout=0 whenever out_valid=0. Without the macro, stale data is allowed on invalid lanes.
